// File: rtl/usb_resp_tx_if.sv
// Handshake bundle between the response framer and its neighbours:
// decoder-side push port, USB-adapter stream port and status.
interface usb_resp_tx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) ();
    logic                          user_valid;
    logic [DATA_WIDTH-1:0]         user_data;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          clr_overflow;

    modport master (
        input  user_valid, user_data, tx_ready, clr_overflow,
        output tx_data, tx_valid, fifo_count, overflow
    );

    modport slave (
        output user_valid, user_data, tx_ready, clr_overflow,
        input  tx_data, tx_valid, fifo_count, overflow
    );
endinterface

// File: rtl/usb_resp_tx.sv
// Device->host response framer: buffers decoder responses and streams them
// as packets (one header word + 1..PKT_WORDS payload words) to the USB adapter.
//
// state   | meaning
// IDLE    | waiting for a full packet's worth of words or the flush timeout
// HEADER  | presenting the header word {HEADER_TAG, 8'h00, n}
// PAYLOAD | presenting buffered words, one pop per transfer, n in total
module usb_resp_tx #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          FIFO_DEPTH    = 16,
    parameter int          PKT_WORDS     = 4,
    parameter int          FLUSH_TIMEOUT = 1024,
    parameter logic [15:0] HEADER_TAG    = 16'hA55A
) (
    input logic          sys_clk,
    input logic          sys_rst,
    usb_resp_tx_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count, count_nxt, start_src;
    logic [TW-1:0]          timer;
    logic [7:0]             n_words, sent, start_n;
    logic                   xfer, pop, push, drop, full, last;
    logic                   idle_start, chain_start;

    function automatic logic [DATA_WIDTH-1:0] header_word(input logic [7:0] n);
        logic [DATA_WIDTH-1:0] w;
        w        = '0;
        w[31:0]  = {HEADER_TAG, 8'h00, n};
        return w;
    endfunction

    always_comb begin
        xfer       = bus.tx_valid & bus.tx_ready;
        pop        = xfer && (state == PAYLOAD);
        full       = (count == CW'(FIFO_DEPTH));
        push       = bus.user_valid && (!full || pop);
        drop       = bus.user_valid && full && !pop;
        count_nxt  = count + CW'(push) - CW'(pop);
        last       = pop && (sent == n_words - 8'd1);
        idle_start = (state == IDLE) &&
                     ((count >= CW'(PKT_WORDS)) ||
                      ((count != '0) && (timer == TW'(FLUSH_TIMEOUT))));
        // back-to-back packets judge the start rule on the post-pop occupancy
        chain_start = last &&
                      ((count_nxt >= CW'(PKT_WORDS)) ||
                       ((count_nxt != '0) && (timer == TW'(FLUSH_TIMEOUT))));
        start_src  = (state == IDLE) ? count : count_nxt;
        start_n    = (start_src >= CW'(PKT_WORDS)) ? 8'(PKT_WORDS) : 8'(start_src);
    end

    // storage has no reset; emptiness is carried by the pointers and count
    always_ff @(posedge sys_clk) begin
        if (push)
            mem[wr_ptr] <= bus.user_data;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            timer        <= '0;
            n_words      <= '0;
            sent         <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
            bus.overflow <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            count  <= count_nxt;

            if (drop)
                bus.overflow <= 1'b1;
            else if (bus.clr_overflow)
                bus.overflow <= 1'b0;

            if (count == '0)
                timer <= '0;
            else if (idle_start || chain_start)
                timer <= '0;
            else if ((state == IDLE) && (count < CW'(PKT_WORDS)))
                timer <= timer + TW'(1);

            case (state)
                IDLE: begin
                    if (idle_start) begin
                        n_words      <= start_n;
                        sent         <= '0;
                        bus.tx_data  <= header_word(start_n);
                        bus.tx_valid <= 1'b1;
                        state        <= HEADER;
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        bus.tx_data <= mem[rd_ptr];
                        state       <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        if (last) begin
                            if (chain_start) begin
                                n_words     <= start_n;
                                sent        <= '0;
                                bus.tx_data <= header_word(start_n);
                                state       <= HEADER;
                            end else begin
                                bus.tx_valid <= 1'b0;
                                bus.tx_data  <= '0;
                                state        <= IDLE;
                            end
                        end else begin
                            sent        <= sent + 8'd1;
                            bus.tx_data <= mem[rd_ptr + AW'(1)];
                        end
                    end
                end
                default: begin
                    bus.tx_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_count = count;
endmodule

// File: tb/tb_usb_resp_tx.sv
// Bench for usb_resp_tx: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_usb_resp_tx;
    localparam int FT = 1024;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    usb_resp_tx_if #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) bus ();

    usb_resp_tx #(
        .DATA_WIDTH(32), .FIFO_DEPTH(16), .PKT_WORDS(4),
        .FLUSH_TIMEOUT(FT), .HEADER_TAG(16'hA55A)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // model: buffered words, plus the frame (header then payload) being sent
    logic [31:0] q[$];
    logic [31:0] pkt[$];
    bit          pkt_hdr;
    bit          m_ovf;
    int          m_timer;
    int          old_cnt, n_start;
    bit          busy, xfer, popq, start;

    function automatic logic [31:0] hdr(input int n);
        return {16'hA55A, 8'h00, 8'(n)};
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            q.delete(); pkt.delete();
            pkt_hdr = 0; m_ovf = 0; m_timer = 0;
        end else begin
            old_cnt = q.size();
            busy    = pkt.size() > 0;
            xfer    = busy && bus.tx_ready;
            popq    = xfer && !pkt_hdr;
            if (xfer) begin
                void'(pkt.pop_front());
                pkt_hdr = 0;
            end
            if (popq) void'(q.pop_front());
            if (bus.user_valid && (old_cnt < 16 || popq)) q.push_back(bus.user_data);
            if (bus.user_valid && old_cnt == 16 && !popq) m_ovf = 1;
            else if (bus.clr_overflow) m_ovf = 0;
            start = 0; n_start = 0;
            if (!busy && (old_cnt >= 4 || (old_cnt > 0 && m_timer == FT))) begin
                start = 1; n_start = (old_cnt < 4) ? old_cnt : 4;
            end else if (busy && pkt.size() == 0 &&
                         (q.size() >= 4 || (q.size() > 0 && m_timer == FT))) begin
                start = 1; n_start = (q.size() < 4) ? q.size() : 4;
            end
            if (old_cnt == 0 || start) m_timer = 0;
            else if (!busy && old_cnt < 4) m_timer++;
            if (start) begin
                pkt.push_back(hdr(n_start));
                for (int i = 0; i < n_start; i++) pkt.push_back(q[i]);
                pkt_hdr = 1;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            chk("tx_valid", 32'(bus.tx_valid), 32'(pkt.size() > 0));
            if (pkt.size() > 0) chk("tx_data", bus.tx_data, pkt[0]);
            chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    logic [31:0] log_q[$];
    always @(negedge sys_clk) begin
        if (!sys_rst && bus.tx_valid && bus.tx_ready) log_q.push_back(bus.tx_data);
    end

    task automatic chk_log(input string name, input logic [31:0] exp[$]);
        chk({name, "_len"}, 32'(log_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < log_q.size()) ? log_q[i] : 32'hFFFF_FFFF, exp[i]);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [31:0] d);
        bus.user_valid = 1'b1;
        bus.user_data  = d;
        tick();
        bus.user_valid = 1'b0;
    endtask

    logic [31:0] w[17];
    logic [31:0] exp_q[$];
    int          waited;

    initial begin
        bus.user_valid = 0; bus.user_data = 0; bus.tx_ready = 0; bus.clr_overflow = 0;
        ticks(3);
        chk("rst_tx_valid", 32'(bus.tx_valid), 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_fifo_count", 32'(bus.fifo_count), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        @(negedge sys_clk) sys_rst = 0;
        tick();

        // 1: full packet
        bus.tx_ready = 1;
        log_q.delete();
        for (int i = 0; i < 4; i++) push(32'h11 + 32'(i));
        ticks(15);
        exp_q = '{32'hA55A0004, 32'h11, 32'h12, 32'h13, 32'h14};
        chk_log("t1_stream", exp_q);
        chk("t1_count", 32'(bus.fifo_count), 0);

        // 2: partial packet flushed by timeout
        log_q.delete();
        push(32'hDEAD);
        ticks(1000);
        chk("t2_quiet", 32'(log_q.size()), 0);
        ticks(40);
        exp_q = '{32'hA55A0001, 32'hDEAD};
        chk_log("t2_stream", exp_q);

        // 3: ready toggling, 4 + timeout 2
        log_q.delete();
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        for (int i = 0; i < 6; i++) push(w[i]);
        for (int i = 0; i < 1200; i++) begin
            bus.tx_ready = ~bus.tx_ready;
            tick();
        end
        bus.tx_ready = 1;
        ticks(10);
        exp_q = '{32'hA55A0004, w[0], w[1], w[2], w[3], 32'hA55A0002, w[4], w[5]};
        chk_log("t3_stream", exp_q);

        // 4: overflow with adapter stalled
        bus.tx_ready = 0;
        log_q.delete();
        for (int i = 0; i < 17; i++) w[i] = $urandom;
        for (int i = 0; i < 17; i++) push(w[i]);
        @(negedge sys_clk);
        chk("t4_count_full", 32'(bus.fifo_count), 16);
        chk("t4_overflow", 32'(bus.overflow), 1);
        tick();
        bus.clr_overflow = 1; tick(); bus.clr_overflow = 0;
        @(negedge sys_clk);
        chk("t4_cleared", 32'(bus.overflow), 0);
        tick();
        bus.tx_ready = 1;
        ticks(40);
        exp_q.delete();
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back(32'hA55A0004);
            for (int i = 0; i < 4; i++) exp_q.push_back(w[p*4+i]);
        end
        chk_log("t4_stream", exp_q);

        // 5: reset in the middle of a payload
        bus.tx_ready = 0;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        for (int i = 0; i < 4; i++) push(w[i]);
        waited = 0;
        while (!bus.tx_valid && waited < 20) begin tick(); waited++; end
        chk("t5_hdr_seen", 32'(bus.tx_valid), 1);
        log_q.delete();
        bus.tx_ready = 1;
        ticks(3);
        bus.tx_ready = 0;
        #2 sys_rst = 1;
        #1;
        chk("t5_valid_in_rst", 32'(bus.tx_valid), 0);
        chk("t5_count_in_rst", 32'(bus.fifo_count), 0);
        @(negedge sys_clk) sys_rst = 0;
        bus.tx_ready = 1;
        ticks(30);
        exp_q = '{32'hA55A0004, w[0], w[1]};
        chk_log("t5_stream", exp_q);

        // 6: push into a full FIFO in a pop cycle
        bus.tx_ready = 0;
        for (int i = 0; i < 16; i++) push($urandom);
        bus.tx_ready = 1;
        tick();
        push(32'hCAFE_F00D);
        @(negedge sys_clk);
        chk("t6_count", 32'(bus.fifo_count), 16);
        chk("t6_overflow", 32'(bus.overflow), 0);
        ticks(60);
        chk("t6_drained", 32'(bus.fifo_count), 1);

        // randomized soak
        for (int i = 0; i < 4000; i++) begin
            bus.user_valid   = ($urandom_range(0, 9) < 3);
            bus.user_data    = $urandom;
            bus.tx_ready     = ($urandom_range(0, 9) < 6);
            bus.clr_overflow = ($urandom_range(0, 49) == 0);
            tick();
        end
        bus.user_valid = 0; bus.clr_overflow = 0; bus.tx_ready = 1;
        ticks(1200);
        chk("soak_drained", 32'(bus.fifo_count), 0);
        chk("soak_idle", 32'(bus.tx_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
